// File: rtl/sa_opnd_skew_feeder_pkg.sv
// Shared geometry and FSM encoding for the systolic-array operand skew feeder.
// Defaults match the PE array edge this block drives.
package sa_opnd_skew_feeder_pkg;

  localparam int SA_OPND_BWIDTH     = 8;
  localparam int SA_NUM_LANES       = 4;
  localparam int SA_NUM_LANES_LOG2  = 2;
  localparam int SA_MAX_K_SIZE_LOG2 = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sa_lane_delay.sv
// Enable-gated shift register with a valid bit; one instance per skew lane.
// Data is forced to zero on the output whenever the valid bit is low.
module sa_lane_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]            vld_q, vld_d, vld_nx;
  logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d, dat_nx;

  if (DEPTH == 1) begin : g_one
    assign vld_nx = in_valid;
    assign dat_nx = in_data;
  end else begin : g_many
    assign vld_nx = {vld_q[DEPTH-2:0], in_valid};
    assign dat_nx = {dat_q[DEPTH-2:0], in_data};
  end

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (en) begin
      vld_d = vld_nx;
      dat_d = dat_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;

endmodule

// File: rtl/sa_opnd_skew_feeder.sv
// Operand skew stage: lane i delayed by 1+i cycles to form the array wavefront.
// Counts K vectors per tile, drains the skew pipe, tags the last element, pulses DONE.
module sa_opnd_skew_feeder
  import sa_opnd_skew_feeder_pkg::*;
#(
  parameter int OPND_BWIDTH     = SA_OPND_BWIDTH,
  parameter int NUM_LANES       = SA_NUM_LANES,
  parameter int NUM_LANES_LOG2  = SA_NUM_LANES_LOG2,
  parameter int MAX_K_SIZE_LOG2 = SA_MAX_K_SIZE_LOG2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           START,
  input  logic                           STALL,
  input  logic [MAX_K_SIZE_LOG2-1:0]     K_SIZE_in,
  input  logic                           VEC_VALID_in,
  output logic                           VEC_READY_out,
  input  logic [NUM_LANES*OPND_BWIDTH-1:0] VEC_DATA_in,
  output logic [NUM_LANES-1:0]           SKEW_VALID_out,
  output logic [NUM_LANES*OPND_BWIDTH-1:0] SKEW_DATA_out,
  output logic                           TILE_LAST_out,
  output logic                           BUSY_out,
  output logic                           DONE_out
);

  localparam int CW = MAX_K_SIZE_LOG2 + 1;
  localparam int FW = NUM_LANES_LOG2;

  state_e                     state_q, state_d;
  logic [MAX_K_SIZE_LOG2-1:0] k_q, k_d;
  logic [CW-1:0]              vec_cnt_q, vec_cnt_d;
  logic [FW-1:0]              flush_cnt_q, flush_cnt_d;
  logic                       en, xfer, last_vec;

  assign en            = ~STALL;
  assign VEC_READY_out = (state_q == ST_FEED) & en;
  assign xfer          = VEC_VALID_in & VEC_READY_out;
  assign last_vec      = vec_cnt_q == (CW'(k_q) - CW'(1));
  assign BUSY_out      = state_q != ST_IDLE;
  // Held in DONE while stalled; the pulse fires once STALL drops.
  assign DONE_out      = (state_q == ST_DONE) & en;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    vec_cnt_d   = vec_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (START) begin
            k_d       = K_SIZE_in;
            vec_cnt_d = '0;
            state_d   = (K_SIZE_in == '0) ? ST_DONE : ST_FEED;
          end
        end
        ST_FEED: begin
          if (xfer) begin
            vec_cnt_d = vec_cnt_q + CW'(1);
            if (last_vec) begin
              state_d     = ST_FLUSH;
              flush_cnt_d = '0;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == FW'(NUM_LANES - 1)) begin
            state_d = ST_DONE;
          end else begin
            flush_cnt_d = flush_cnt_q + FW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      vec_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      vec_cnt_q   <= vec_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [OPND_BWIDTH-1:0] in_d;
    assign in_d = xfer ? VEC_DATA_in[i*OPND_BWIDTH +: OPND_BWIDTH] : '0;
    if (i == NUM_LANES - 1) begin : g_tag
      // The deepest lane carries the last-element flag alongside its data.
      logic [OPND_BWIDTH:0] out_w;
      sa_lane_delay #(
        .WIDTH (OPND_BWIDTH + 1),
        .DEPTH (i + 1)
      ) u_dly (
        .clk       (CLK),
        .rst       (RST),
        .en        (en),
        .in_valid  (xfer),
        .in_data   ({xfer & last_vec, in_d}),
        .out_valid (SKEW_VALID_out[i]),
        .out_data  (out_w)
      );
      assign SKEW_DATA_out[i*OPND_BWIDTH +: OPND_BWIDTH] = out_w[OPND_BWIDTH-1:0];
      assign TILE_LAST_out = out_w[OPND_BWIDTH];
    end else begin : g_plain
      sa_lane_delay #(
        .WIDTH (OPND_BWIDTH),
        .DEPTH (i + 1)
      ) u_dly (
        .clk       (CLK),
        .rst       (RST),
        .en        (en),
        .in_valid  (xfer),
        .in_data   (in_d),
        .out_valid (SKEW_VALID_out[i]),
        .out_data  (SKEW_DATA_out[i*OPND_BWIDTH +: OPND_BWIDTH])
      );
    end
  end

endmodule

// File: tb/tb_sa_opnd_skew_feeder.sv
// Bench for sa_opnd_skew_feeder: directed tiles plus random tiles against
// a timeline model keyed by the count of unstalled clock edges.
module tb_sa_opnd_skew_feeder;

  localparam int NL = 4;
  localparam int OW = 8;
  localparam int KW = 9;
  localparam int NEVER = 32'h7fffffff;

  logic              CLK = 1'b0;
  logic              RST, START, STALL, VEC_VALID_in;
  logic              VEC_READY_out, TILE_LAST_out, BUSY_out, DONE_out;
  logic [KW-1:0]     K_SIZE_in;
  logic [NL*OW-1:0]  VEC_DATA_in, SKEW_DATA_out;
  logic [NL-1:0]     SKEW_VALID_out;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Model: m_uc counts unstalled edges; ev maps (edge count, lane) to {last, data}.
  int  m_uc = 0, m_k = 0, m_got = 0, m_done_at = NEVER;
  bit  m_act = 0, m_x = 0, m_sawdone = 0;
  logic [OW:0]      ev [int];
  logic [NL*OW-1:0] vq [$];

  sa_opnd_skew_feeder dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .STALL          (STALL),
    .K_SIZE_in      (K_SIZE_in),
    .VEC_VALID_in   (VEC_VALID_in),
    .VEC_READY_out  (VEC_READY_out),
    .VEC_DATA_in    (VEC_DATA_in),
    .SKEW_VALID_out (SKEW_VALID_out),
    .SKEW_DATA_out  (SKEW_DATA_out),
    .TILE_LAST_out  (TILE_LAST_out),
    .BUSY_out       (BUSY_out),
    .DONE_out       (DONE_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    logic [OW:0] e;
    bit          v;
    bit          lst;
    lst = 0;
    for (int i = 0; i < NL; i++) begin
      v = ev.exists(m_uc*NL + i);
      e = v ? ev[m_uc*NL + i] : '0;
      chk($sformatf("skew_valid%0d", i), 32'(SKEW_VALID_out[i]), 32'(v));
      chk($sformatf("skew_data%0d", i), 32'(SKEW_DATA_out[i*OW +: OW]), 32'(e[OW-1:0]));
      if (i == NL - 1) lst = v & e[OW];
    end
    chk("tile_last", 32'(TILE_LAST_out), 32'(lst));
    chk("busy", 32'(BUSY_out), 32'(m_act));
  endtask

  task automatic cyc();
    bit xf;
    #1;
    xf = m_act && (m_got < m_k) && !STALL && VEC_VALID_in;
    chk("ready", 32'(VEC_READY_out), 32'(m_act && (m_got < m_k) && !STALL));
    chk("done", 32'(DONE_out), 32'(m_act && (m_uc == m_done_at) && !STALL));
    m_sawdone = DONE_out;
    m_x = xf;
    @(posedge CLK);
    if (!STALL) begin
      if (xf) begin
        m_got++;
        for (int i = 0; i < NL; i++)
          ev[(m_uc + i + 1)*NL + i] = {(i == NL - 1) && (m_got == m_k),
                                      VEC_DATA_in[i*OW +: OW]};
        if (m_got == m_k) m_done_at = m_uc + NL + 1;
      end else if (!m_act && START) begin
        m_act = 1;
        m_k = int'(K_SIZE_in);
        m_got = 0;
        m_done_at = (K_SIZE_in == '0) ? m_uc + 1 : NEVER;
      end
      m_uc++;
      if (m_act && m_uc > m_done_at) m_act = 0;
    end
    #1;
    check_out();
  endtask

  task automatic do_reset();
    START = 0;
    STALL = 0;
    VEC_VALID_in = 0;
    RST = 1;
    #1;
    chk("rst_valid", 32'(SKEW_VALID_out), 0);
    chk("rst_data", SKEW_DATA_out, 0);
    chk("rst_last", 32'(TILE_LAST_out), 0);
    chk("rst_busy", 32'(BUSY_out), 0);
    chk("rst_done", 32'(DONE_out), 0);
    chk("rst_ready", 32'(VEC_READY_out), 0);
    ev.delete();
    m_act = 0;
    m_k = 0;
    m_got = 0;
    m_done_at = NEVER;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 0;
    check_out();
  endtask

  task automatic run_tile(input int k, input bit hold, input int pv, input int ps,
                          input logic [31:0] smask, input logic [31:0] gmask,
                          input int exp_done, input int abort_j);
    int j;
    int dj;
    STALL = 0;
    VEC_VALID_in = 0;
    START = 1;
    K_SIZE_in = KW'(k);
    cyc();
    START = hold;
    K_SIZE_in = KW'($urandom);
    j = 0;
    dj = -1;
    while (m_act && j < 20000 && j != abort_j) begin
      STALL = ((j < 32) && smask[j[4:0]]) || ($urandom_range(99) < ps);
      VEC_VALID_in = !((j < 32) && gmask[j[4:0]]) && ($urandom_range(99) < pv);
      VEC_DATA_in = (vq.size() > 0) ? vq[0] : $urandom;
      cyc();
      if (m_sawdone) dj = j;
      if (m_x && vq.size() > 0) void'(vq.pop_front());
      j++;
    end
    if (abort_j < 0) chk("tile_end", 32'(m_act), 0);
    if (exp_done >= 0) chk("done_cycle", dj, exp_done);
    START = 0;
    STALL = 0;
    VEC_VALID_in = 0;
  endtask

  task automatic fill(input int k);
    vq.delete();
    for (int i = 0; i < k; i++) vq.push_back($urandom);
  endtask

  initial begin
    RST = 0;
    START = 0;
    STALL = 0;
    VEC_VALID_in = 0;
    VEC_DATA_in = '0;
    K_SIZE_in = '0;
    #2;
    do_reset();

    vq = '{32'h04030201, 32'h14131211, 32'h24232221};
    run_tile(3, 0, 100, 0, 0, 0, 7, -1);

    vq = '{32'h04030201, 32'h14131211, 32'h24232221};
    run_tile(3, 0, 100, 0, 0, 32'h2, 8, -1);

    fill(4);
    run_tile(4, 0, 100, 0, 32'h186, 0, 12, -1);

    vq.delete();
    run_tile(0, 0, 100, 0, 0, 0, 0, -1);

    fill(5);
    run_tile(5, 0, 100, 0, 0, 0, -1, 7);
    do_reset();
    fill(2);
    run_tile(2, 0, 100, 0, 0, 0, 6, -1);

    fill(2);
    run_tile(2, 1, 100, 0, 0, 0, 6, -1);
    fill(2);
    run_tile(2, 1, 100, 0, 0, 0, 6, -1);

    fill(511);
    run_tile(511, 0, 100, 0, 0, 0, 515, -1);

    for (int t = 0; t < 4; t++) begin
      int k;
      k = $urandom_range(511, 1);
      fill(k);
      run_tile(k, t[0], 70, 20, 0, 0, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
